// File: rtl/mips_dmem_port.sv
// mips_dmem_port: word-addressed data memory behind a valid/ready request port
// with a one-cycle response pulse, WAIT_CYC wait states, byte-enable writes and
// a debug preload/readback port.
// Optional feature: define DMEM_RANGE_CHECK_EN to flag accesses at or above
// DEPTH with rsp_err and return zero data for them.
module mips_dmem_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 0
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  input  logic                  dbg_we,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic                acc, exec;

  // request fields held across the wait states
  logic                cap_we;
  logic [NB-1:0]       cap_be;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  // fields of the access executing on this edge
  logic                ex_we;
  logic [NB-1:0]       ex_be;
  logic [ADDR_W-1:0]   ex_addr;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_inr;

  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  assign req_ready = (state != S_WAIT) && !dbg_we;
  assign acc       = req_valid && req_ready;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state == S_WAIT);

  // zero wait states execute straight from the request inputs on the accepting edge
  always_comb begin
    if (WAIT_CYC == 0) begin
      ex_we    = req_we;
      ex_be    = req_be;
      ex_addr  = req_addr;
      ex_wdata = req_wdata;
    end else begin
      ex_we    = cap_we;
      ex_be    = cap_be;
      ex_addr  = cap_addr;
      ex_wdata = cap_wdata;
    end
    ex_inr = in_rng(ex_addr);
  end

  // next-state, wait counter and execute strobe
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exec    = 1'b0;
    case (state)
      S_IDLE, S_RESP: begin
        if (acc) begin
          if (WAIT_CYC == 0) begin
            exec    = 1'b1;
            state_n = S_RESP;
          end else begin
            cnt_n   = 4'(WAIT_CYC - 1);
            state_n = S_WAIT;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          exec    = 1'b1;
          state_n = S_RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // state register and wait counter
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // capture request fields on acceptance so later input changes are ignored
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (acc) begin
      cap_we    <= req_we;
      cap_be    <= req_be;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // array update: debug word write first so a same-edge core write wins per byte
  always_ff @(posedge clk1) begin
    if (dbg_we && in_rng(dbg_addr))
      mem[dbg_addr[IW-1:0]] <= dbg_wdata;
    if (exec && ex_we && ex_inr)
      for (int i = 0; i < NB; i++)
        if (ex_be[i]) mem[ex_addr[IW-1:0]][i*8 +: 8] <= ex_wdata[i*8 +: 8];
  end

  // response data/error, loaded from pre-edge array contents
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (exec) begin
      rsp_err <= RANGE_CHK && !ex_inr;
      if (!ex_we)
        rsp_rdata <= ex_inr ? mem[ex_addr[IW-1:0]] : '0;
      else if (RANGE_CHK && !ex_inr)
        rsp_rdata <= '0;
    end
  end

  // debug readback, one cycle latency
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) dbg_rdata <= '0;
    else        dbg_rdata <= in_rng(dbg_addr) ? mem[dbg_addr[IW-1:0]] : '0;
  end

endmodule

// File: tb/tb_mips_dmem_port.sv
// tb_mips_dmem_port: two ports (0 and 3 wait states) driven with shared random
// traffic, checked against a transaction-level memory model.
module tb_mips_dmem_port;
  localparam int AW  = 10;
  localparam int DEP = 256;
`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic            rst_n;
  logic            req_valid, req_we, dbg_we;
  logic [3:0]      req_be;
  logic [AW-1:0]   req_addr, dbg_addr;
  logic [31:0]     req_wdata, dbg_wdata;
  logic [1:0]      ready, rv, err, busy;
  logic [1:0][31:0] rd, drd;

  mips_dmem_port #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYC(0)) u_w0 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(drd[0]), .busy(busy[0]));

  mips_dmem_port #(.DATA_W(32), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYC(3)) u_w3 (
    .clk1(clk1), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
    .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(drd[1]), .busy(busy[1]));

  // reference model: per port, one pending transaction that executes at a known edge
  int          k;
  int          wc [2] = '{0, 3};
  bit          pend [2];
  int          ex_edge [2], last_ex [2];
  logic        p_we [2];
  logic [3:0]  p_be [2];
  logic [AW-1:0] p_addr [2];
  logic [31:0] p_wd [2];
  logic [31:0] e_rd [2], e_dbg [2];
  bit          e_err [2], e_dbg_ok [2];
  logic [31:0] m [2][DEP];
  bit          kn [2][DEP];
  int          n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_rst();
    for (int d = 0; d < 2; d++) begin
      pend[d] = 0; last_ex[d] = -100; e_rd[d] = '0; e_err[d] = 0;
      e_dbg[d] = '0; e_dbg_ok[d] = 1;
    end
  endtask

  task automatic check_regs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rsp_valid[%0d]", d), 32'(rv[d]), 32'(last_ex[d] == k));
      if (last_ex[d] == k) begin
        chk($sformatf("rsp_rdata[%0d]", d), rd[d], e_rd[d]);
        chk($sformatf("rsp_err[%0d]", d), 32'(err[d]), 32'(e_err[d]));
      end
      chk($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(pend[d]));
      if (e_dbg_ok[d]) chk($sformatf("dbg_rdata[%0d]", d), drd[d], e_dbg[d]);
    end
  endtask

  // one clock: check registered outputs, drive inputs, advance model to next edge
  task automatic cyc(input logic v, input logic we, input logic [3:0] be,
                     input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic dw, input logic [AW-1:0] da, input logic [31:0] dd);
    bit acc, do_ex, inr;
    logic [31:0] pre;
    @(negedge clk1);
    check_regs();
    req_valid = v; req_we = we; req_be = be; req_addr = a; req_wdata = wd;
    dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("req_ready[%0d]", d), 32'(ready[d]), 32'(!pend[d] && !dw));
      e_dbg[d]    = m[d][da[7:0]];
      e_dbg_ok[d] = kn[d][da[7:0]];
      acc = v && !pend[d] && !dw;
      if (acc) begin
        pend[d] = 1; p_we[d] = we; p_be[d] = be; p_addr[d] = a; p_wd[d] = wd;
        ex_edge[d] = k + 1 + wc[d];
      end
      do_ex = pend[d] && (ex_edge[d] == k + 1);
      inr = 0;
      if (do_ex) begin
        pend[d] = 0; last_ex[d] = k + 1;
        inr = (int'(p_addr[d]) < DEP);
        pre = inr ? m[d][p_addr[d][7:0]] : 32'h0;
        if (!p_we[d]) e_rd[d] = pre;
        else if (RC && !inr) e_rd[d] = '0;
        e_err[d] = RC && !inr;
      end
      if (dw) begin
        m[d][da[7:0]] = dd; kn[d][da[7:0]] = 1;
      end
      if (do_ex && p_we[d] && inr)
        for (int i = 0; i < 4; i++)
          if (p_be[d][i]) m[d][p_addr[d][7:0]][i*8 +: 8] = p_wd[d][i*8 +: 8];
    end
    @(posedge clk1);
    k++;
  endtask

  task automatic idle(input int n, input logic [AW-1:0] da);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, '0, '0, 0, da, '0);
  endtask

  task automatic reset_pulse();
    @(negedge clk1);
    req_valid = 0; dbg_we = 0; rst_n = 0;
    model_rst();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst rsp_valid[%0d]", d), 32'(rv[d]), 32'h0);
      chk($sformatf("rst rsp_rdata[%0d]", d), rd[d], 32'h0);
      chk($sformatf("rst rsp_err[%0d]", d), 32'(err[d]), 32'h0);
      chk($sformatf("rst dbg_rdata[%0d]", d), drd[d], 32'h0);
      chk($sformatf("rst busy[%0d]", d), 32'(busy[d]), 32'h0);
      chk($sformatf("rst req_ready[%0d]", d), 32'(ready[d]), 32'h1);
    end
    repeat (2) begin @(posedge clk1); k++; end
    @(negedge clk1);
    rst_n = 1;
    for (int d = 0; d < 2; d++) e_dbg_ok[d] = 0;
    @(posedge clk1);
    k++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    n_tests = 0; n_fail = 0; k = 0;
    rst_n = 0; req_valid = 0; req_we = 0; req_be = '0; req_addr = '0;
    req_wdata = '0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    model_rst();
    reset_pulse();

    // preload the working window through the debug port
    for (int i = 0; i < 16; i++) cyc(0, 0, 4'h0, '0, '0, 1, AW'(i), $urandom);
    cyc(0, 0, 4'h0, '0, '0, 1, 10'd64, 32'd121);
    cyc(1, 0, 4'h0, 10'd64, '0, 0, 10'd64, '0);
    idle(5, 10'd64);

    // byte-enable merge
    cyc(0, 0, 4'h0, '0, '0, 1, 10'd62, 32'hAABBCCDD);
    cyc(1, 1, 4'b0011, 10'd62, 32'h00001E40, 0, 10'd62, '0);
    idle(6, 10'd62);
    chk("be_merge w0", drd[0], 32'hAABB1E40);
    chk("be_merge w3", drd[1], 32'hAABB1E40);

    // back-to-back write then read of the same word
    cyc(1, 1, 4'hF, 10'd62, 32'd7744, 0, 10'd62, '0);
    cyc(1, 0, 4'h0, 10'd62, '0, 0, 10'd62, '0);
    idle(6, 10'd62);

    // debug write holds off acceptance
    for (int i = 0; i < 3; i++) cyc(1, 0, 4'h0, 10'd3, '0, 1, 10'd4, $urandom);
    cyc(1, 0, 4'h0, 10'd3, '0, 0, 10'd4, '0);
    idle(6, 10'd4);

    // out-of-range write then read
    cyc(1, 1, 4'hF, 10'd300, 32'hDEADBEEF, 0, 10'd0, '0);
    idle(5, 10'd0);
    cyc(1, 0, 4'h0, 10'd300, '0, 0, 10'd0, '0);
    idle(5, 10'd0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 7))
        0:       a = AW'(256 + $urandom_range(0, 60));
        1:       a = 10'd62;
        default: a = AW'($urandom_range(0, 15));
      endcase
      cyc(($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom), a, $urandom,
          ($urandom_range(0, 5) == 0), AW'($urandom_range(0, 15)), $urandom);
    end
    idle(6, 10'd5);

    // reset in the middle of a waited write drops it
    cyc(0, 0, 4'h0, '0, '0, 1, 10'd5, 32'h11);
    cyc(1, 1, 4'hF, 10'd5, 32'h99, 0, 10'd5, '0);
    cyc(0, 0, 4'h0, '0, '0, 0, 10'd5, '0);
    reset_pulse();
    idle(5, 10'd5);
    chk("rst_drop w3", drd[1], 32'h11);
    chk("rst_keep w0", drd[0], 32'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
